sw_run_ctrl: RTL and testbench

Run/pause/lap controller for the stopwatch counter datapath. Conditions the raw board controls (SW2 enable, SW3 fast mode, KEY3 start/pause, KEY2 lap/clear) through synchronisers and debouncers. Sequences a four-state FSM and emits the one-cycle increment strobe and clear pulse that drive the BCD stopwatch counter chain. Provides a display-freeze flag for lap hold. Sits between the board I/O and the stopwatch counter and display mux.

---
 rtl/sw_ctrl_pkg.sv | 23 ++
 rtl/sw_key_cond.sv | 59 +++++
 rtl/sw_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_sw_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_ctrl_pkg.sv
// Shared types and default constants for the stopwatch run/pause/lap controller.
//   sw_state_e : controller state, 2-bit encoding visible on SW_STATE
//   key_evt_t  : one-cycle rise/fall events from a conditioned control input
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_LAP    = 2'b11
  } sw_state_e;

  typedef struct packed {
    logic rise;
    logic fall;
  } key_evt_t;

  localparam int unsigned TICK_DIV_DEF = 5000;
  localparam int unsigned FAST_DIV_DEF = 50;
  localparam int unsigned DEB_LEN_DEF  = 4;
  localparam int unsigned PRE_W_DEF    = 13;

endpackage

// File: rtl/sw_key_cond.sv
// Conditions one raw board control: 2-flop synchroniser, debounce counter,
// and registered one-cycle rise/fall events of the debounced level.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   raw_i        : raw asynchronous level
//   evt_o        : rise/fall pulses, DEB_LEN+2 cycles after the raw change
module sw_key_cond
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned DEB_LEN = DEB_LEN_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     raw_i,
  output key_evt_t evt_o
);

  localparam int unsigned CNT_W = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_evt_t         evt_q;

  // Debounce: follow the synchronised level once it has disagreed for DEB_LEN cycles in a row.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEB_LEN - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      evt_q.rise <= deb_q & ~deb_dly_q;
      evt_q.fall <= ~deb_q & deb_dly_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/sw_run_ctrl.sv
// Stopwatch run/pause/lap controller: conditions SW2/SW3/KEY3/KEY2, runs the
// OFF/RUN/PAUSED/LAP state machine and the tick prescaler.
//   CLK, RST  : clock, asynchronous active-high reset
//   SW2       : enable switch      SW3  : fast-mode switch
//   KEY3      : start/pause key    KEY2 : lap/clear key
//   SW_ACTIVE : not OFF            SW_RUN    : RUN or LAP
//   SW_TICK   : counter increment  SW_CLR    : counter clear
//   SW_FREEZE : display hold (LAP) SW_STATE  : state encoding
module sw_run_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned FAST_DIV = FAST_DIV_DEF,
  parameter int unsigned DEB_LEN  = DEB_LEN_DEF,
  parameter int unsigned PRE_W    = PRE_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       KEY3,
  input  logic       KEY2,
  output logic       SW_ACTIVE,
  output logic       SW_RUN,
  output logic       SW_TICK,
  output logic       SW_CLR,
  output logic       SW_FREEZE,
  output logic [1:0] SW_STATE
);

  key_evt_t   sw2_evt, key3_evt, key2_evt;
  logic       sw3_s1_q, sw3_s2_q;
  logic       unused_fall;

  sw_state_e  state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d, div;
  logic       tick_q, tick_d;
  logic       clr_q, clr_d;
  logic       active_q, active_d;
  logic       run_q, run_d;
  logic       freeze_q, freeze_d;

  sw_key_cond #(.DEB_LEN(DEB_LEN)) u_sw2 (.clk_i(CLK), .rst_i(RST), .raw_i(SW2),  .evt_o(sw2_evt));
  sw_key_cond #(.DEB_LEN(DEB_LEN)) u_k3  (.clk_i(CLK), .rst_i(RST), .raw_i(KEY3), .evt_o(key3_evt));
  sw_key_cond #(.DEB_LEN(DEB_LEN)) u_k2  (.clk_i(CLK), .rst_i(RST), .raw_i(KEY2), .evt_o(key2_evt));

  // Key releases carry no meaning for the controller.
  assign unused_fall = key3_evt.fall ^ key2_evt.fall;

  assign div = sw3_s2_q ? PRE_W'(FAST_DIV) : PRE_W'(TICK_DIV);

  // Next state, prescaler and output decode.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;

    // Switch-off outranks any key event in the same cycle.
    if (state_q != ST_OFF && sw2_evt.fall) begin
      state_d = ST_OFF;
      clr_d   = 1'b1;
    end else if (state_q == ST_OFF && sw2_evt.rise) begin
      state_d = ST_RUN;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (key3_evt.rise)      state_d = ST_PAUSED;
          else if (key2_evt.rise) state_d = ST_LAP;
        end
        ST_PAUSED: begin
          if (key3_evt.rise)      state_d = ST_RUN;
          else if (key2_evt.rise) clr_d   = 1'b1;
        end
        ST_LAP: begin
          if (key3_evt.rise)      state_d = ST_PAUSED;
          else if (key2_evt.rise) state_d = ST_RUN;
        end
        default: ;
      endcase
    end

    // A clear cycle zeroes the prescaler and suppresses any tick.
    if (clr_d) begin
      pre_d = '0;
    end else begin
      case (state_q)
        ST_RUN, ST_LAP: begin
          if (pre_q == div - PRE_W'(1)) begin
            pre_d  = '0;
            tick_d = 1'b1;
          end else if (pre_q >= div) begin
            // Leftover count from the slow divisor after switching to fast mode.
            pre_d = '0;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        ST_PAUSED: pre_d = pre_q;
        default:   pre_d = '0;
      endcase
    end

    active_d = (state_d != ST_OFF);
    run_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
    freeze_d = (state_d == ST_LAP);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw3_s1_q <= 1'b0;
      sw3_s2_q <= 1'b0;
      state_q  <= ST_OFF;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      clr_q    <= 1'b0;
      active_q <= 1'b0;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      sw3_s1_q <= SW3;
      sw3_s2_q <= sw3_s1_q;
      state_q  <= state_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      clr_q    <= clr_d;
      active_q <= active_d;
      run_q    <= run_d;
      freeze_q <= freeze_d;
    end
  end

  assign SW_STATE  = state_q;
  assign SW_ACTIVE = active_q;
  assign SW_RUN    = run_q;
  assign SW_TICK   = tick_q;
  assign SW_CLR    = clr_q;
  assign SW_FREEZE = freeze_q;

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Bench for sw_run_ctrl: behavioural model compared every cycle, plus
// hand-computed expectations for the key scenarios.
module tb_sw_run_ctrl;

  localparam int TB_TICK = 10;
  localparam int TB_FAST = 3;
  localparam int TB_DEB  = 4;
  localparam int TB_PRE_W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SW2 = 1'b0, SW3 = 1'b0, KEY3 = 1'b0, KEY2 = 1'b0;
  logic SW_ACTIVE, SW_RUN, SW_TICK, SW_CLR, SW_FREEZE;
  logic [1:0] SW_STATE;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  sw_run_ctrl #(
    .TICK_DIV(TB_TICK), .FAST_DIV(TB_FAST), .DEB_LEN(TB_DEB), .PRE_W(TB_PRE_W)
  ) dut (
    .CLK(CLK), .RST(RST), .SW2(SW2), .SW3(SW3), .KEY3(KEY3), .KEY2(KEY2),
    .SW_ACTIVE(SW_ACTIVE), .SW_RUN(SW_RUN), .SW_TICK(SW_TICK), .SW_CLR(SW_CLR),
    .SW_FREEZE(SW_FREEZE), .SW_STATE(SW_STATE)
  );

  always #5 CLK = ~CLK;

  // Model: raw sample histories (bit 0 = this edge), debounced level
  // histories (bit 0 = after previous edge), state 0..3, prescaler count.
  typedef struct packed {
    logic [TB_DEB+1:0] h_sw2;
    logic [TB_DEB+1:0] h_k3;
    logic [TB_DEB+1:0] h_k2;
    logic [2:0]        h_sw3;
    logic [2:0]        d_sw2;
    logic [2:0]        d_k3;
    logic [2:0]        d_k2;
    logic [1:0]        st;
    logic [7:0]        pre;
    logic              tick;
    logic              clr;
  } model_t;

  model_t m;

  // Debounced level follows once the last DEB_LEN synchronised samples all oppose it.
  function automatic logic settle(input logic [TB_DEB+1:0] h, input logic cur);
    logic [TB_DEB-1:0] w;
    w = h[TB_DEB+1:2];
    return cur ? (w != '0) : (w == '1);
  endfunction

  function automatic model_t step(input model_t mi, input logic sw2, input logic sw3,
                                  input logic k3, input logic k2);
    model_t n;
    logic s2r, s2f, k3r, k2r;
    int div;
    n = mi;
    n.tick = 1'b0;
    n.clr  = 1'b0;
    n.h_sw2 = {mi.h_sw2[TB_DEB:0], sw2};
    n.h_k3  = {mi.h_k3[TB_DEB:0], k3};
    n.h_k2  = {mi.h_k2[TB_DEB:0], k2};
    n.h_sw3 = {mi.h_sw3[1:0], sw3};
    n.d_sw2 = {mi.d_sw2[1:0], settle(n.h_sw2, mi.d_sw2[0])};
    n.d_k3  = {mi.d_k3[1:0],  settle(n.h_k3,  mi.d_k3[0])};
    n.d_k2  = {mi.d_k2[1:0],  settle(n.h_k2,  mi.d_k2[0])};
    // Controller reacts to a debounced change made two edges earlier.
    s2r = mi.d_sw2[1] & ~mi.d_sw2[2];
    s2f = ~mi.d_sw2[1] & mi.d_sw2[2];
    k3r = mi.d_k3[1] & ~mi.d_k3[2];
    k2r = mi.d_k2[1] & ~mi.d_k2[2];
    div = n.h_sw3[2] ? TB_FAST : TB_TICK;

    if (mi.st != 2'd0 && s2f) begin n.st = 2'd0; n.clr = 1'b1; end
    else if (mi.st == 2'd0 && s2r) begin n.st = 2'd1; n.clr = 1'b1; end
    else if (mi.st == 2'd1) begin
      if (k3r) n.st = 2'd2; else if (k2r) n.st = 2'd3;
    end else if (mi.st == 2'd2) begin
      if (k3r) n.st = 2'd1; else if (k2r) n.clr = 1'b1;
    end else if (mi.st == 2'd3) begin
      if (k3r) n.st = 2'd2; else if (k2r) n.st = 2'd1;
    end

    if (n.clr || mi.st == 2'd0) n.pre = 8'd0;
    else if (mi.st == 2'd1 || mi.st == 2'd3) begin
      if (int'(mi.pre) == div - 1) begin n.pre = 8'd0; n.tick = 1'b1; end
      else if (int'(mi.pre) >= div) n.pre = 8'd0;
      else n.pre = 8'(int'(mi.pre) + 1);
    end
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= '0;
    else     m <= step(m, SW2, SW3, KEY3, KEY2);
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_state",  8'(SW_STATE),  8'(m.st));
      chk("m_active", 8'(SW_ACTIVE), 8'(m.st != 2'd0));
      chk("m_run",    8'(SW_RUN),    8'(m.st == 2'd1 || m.st == 2'd3));
      chk("m_freeze", 8'(SW_FREEZE), 8'(m.st == 2'd3));
      chk("m_tick",   8'(SW_TICK),   8'(m.tick));
      chk("m_clr",    8'(SW_CLR),    8'(m.clr));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input int which, input int len);
    @(negedge CLK); #1;
    if (which == 3) KEY3 = 1'b1; else KEY2 = 1'b1;
    repeat (len) @(negedge CLK);
    #1;
    if (which == 3) KEY3 = 1'b0; else KEY2 = 1'b0;
  endtask

  initial begin
    int nclr;
    wait_cyc(3);
    chk("rst_state",  8'(SW_STATE),  8'd0);
    chk("rst_active", 8'(SW_ACTIVE), 8'd0);
    chk("rst_run",    8'(SW_RUN),    8'd0);
    chk("rst_tick",   8'(SW_TICK),   8'd0);
    chk("rst_clr",    8'(SW_CLR),    8'd0);
    chk("rst_freeze", 8'(SW_FREEZE), 8'd0);
    #1 RST = 1'b0;
    cmp_en = 1'b1;
    wait_cyc(3);

    // Enable at edge 0: RUN + clear in cycle 7, ticks at 17 and 27.
    @(negedge CLK); #1 SW2 = 1'b1;
    @(posedge CLK);
    for (int k = 0; k <= 27; k++) begin
      @(negedge CLK);
      if (k == 6) chk("pre_enable_state", 8'(SW_STATE), 8'd0);
      if (k == 7) begin
        chk("enable_state", 8'(SW_STATE), 8'd1);
        chk("enable_clr",   8'(SW_CLR),   8'd1);
      end
      if (k >= 8) chk("tick_sched", 8'(SW_TICK), (k == 17 || k == 27) ? 8'd1 : 8'd0);
    end

    // Pause: silent while paused, then resume.
    press(3, 8);
    wait_cyc(10);
    chk("pause_state", 8'(SW_STATE), 8'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("pause_no_tick", 8'(SW_TICK), 8'd0);
    end
    press(3, 8);
    wait_cyc(10);
    chk("resume_state", 8'(SW_STATE), 8'd1);
    wait_cyc(4);

    // Fast mode then back to normal.
    @(negedge CLK); #1 SW3 = 1'b1;
    wait_cyc(40);
    #1 SW3 = 1'b0;
    wait_cyc(20);

    // Lap hold and release.
    press(2, 8);
    wait_cyc(10);
    chk("lap_freeze", 8'(SW_FREEZE), 8'd1);
    chk("lap_state",  8'(SW_STATE),  8'd3);
    wait_cyc(15);
    press(2, 8);
    wait_cyc(10);
    chk("unlap_freeze", 8'(SW_FREEZE), 8'd0);
    chk("unlap_state",  8'(SW_STATE),  8'd1);

    // KEY2 while paused: one clear, state stays PAUSED.
    press(3, 8);
    wait_cyc(10);
    nclr = 0;
    @(negedge CLK); #1 KEY2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      nclr += int'(SW_CLR);
      chk("paused_hold_state", 8'(SW_STATE), 8'd2);
      if (i == 7) #1 KEY2 = 1'b0;
    end
    chk("paused_clr_count", 8'(nclr), 8'd1);
    press(3, 8);
    wait_cyc(10);

    // Simultaneous KEY3 and KEY2: pause wins.
    @(negedge CLK); #1 KEY3 = 1'b1; KEY2 = 1'b1;
    wait_cyc(8);
    #1 KEY3 = 1'b0; KEY2 = 1'b0;
    wait_cyc(10);
    chk("both_keys_state", 8'(SW_STATE), 8'd2);
    press(3, 8);
    wait_cyc(10);

    // Short glitch is ignored.
    press(3, 3);
    wait_cyc(15);
    chk("glitch_state", 8'(SW_STATE), 8'd1);

    // Switch off while in LAP.
    press(2, 8);
    wait_cyc(10);
    nclr = 0;
    @(negedge CLK); #1 SW2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      nclr += int'(SW_CLR);
    end
    chk("off_state",  8'(SW_STATE),  8'd0);
    chk("off_freeze", 8'(SW_FREEZE), 8'd0);
    chk("off_active", 8'(SW_ACTIVE), 8'd0);
    chk("off_clr_count", 8'(nclr), 8'd1);
    #1 SW2 = 1'b1;
    wait_cyc(15);

    // Asynchronous reset mid-run, then re-enable with SW2 still high.
    @(negedge CLK); #2 RST = 1'b1;
    #1;
    chk("arst_state",  8'(SW_STATE),  8'd0);
    chk("arst_active", 8'(SW_ACTIVE), 8'd0);
    chk("arst_run",    8'(SW_RUN),    8'd0);
    chk("arst_tick",   8'(SW_TICK),   8'd0);
    chk("arst_clr",    8'(SW_CLR),    8'd0);
    chk("arst_freeze", 8'(SW_FREEZE), 8'd0);
    wait_cyc(2);
    #1 RST = 1'b0;
    wait_cyc(12);
    chk("rearm_state", 8'(SW_STATE), 8'd1);

    // Randomised control activity, checked against the model.
    for (int seg = 0; seg < 400; seg++) begin
      @(negedge CLK); #1;
      SW2  = ($urandom_range(0, 19) != 0);
      SW3  = ($urandom_range(0, 2) == 0);
      KEY3 = ($urandom_range(0, 3) == 0);
      KEY2 = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 12)) @(negedge CLK);
    end
    wait_cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
